// File: rtl/bus_arb_pkg.sv
// ---------------------------------------------------------------------------
// bus_arb_pkg
// Shared constants and small elaboration-time helpers for the N-master bus
// arbiter and its response-ID FIFO.
//   ARB_FIXED / ARB_RR : values of the arbiter's ARB_MODE parameter
//   idx_width()        : bits needed to index n items (minimum 1)
//   cnt_width()        : bits needed to count 0..depth inclusive
//   wrap_idx()         : single-step modulo for values below 2*n
// ---------------------------------------------------------------------------
package bus_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Callers only ever pass idx < 2*n, so one conditional subtract is enough.
    function automatic int wrap_idx(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr_if
// req/we/addr/be/wdata/ack/resp/rdata bus bundle. NUM_PORTS packs several
// independent buses side by side (port k at [k*W +: W]) so one interface type
// serves both the multi-master side and the single slave side of the arbiter.
//   master modport : drives req/we/addr/be/wdata, receives ack/resp/rdata
//   slave  modport : receives req/we/addr/be/wdata, drives ack/resp/rdata
// ---------------------------------------------------------------------------
interface bus_arbiter_rr_if
    import bus_arb_pkg::*;
#(
    parameter int NUM_PORTS = 1,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);

    logic [NUM_PORTS-1:0]          req;
    logic [NUM_PORTS-1:0]          we;
    logic [NUM_PORTS*ADDR_W-1:0]   addr;
    logic [NUM_PORTS*DATA_W/8-1:0] be;
    logic [NUM_PORTS*DATA_W-1:0]   wdata;
    logic [NUM_PORTS-1:0]          ack;
    logic [NUM_PORTS-1:0]          resp;
    logic [NUM_PORTS*DATA_W-1:0]   rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, resp, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, resp, rdata
    );

endinterface

// File: rtl/bus_id_fifo.sv
// ---------------------------------------------------------------------------
// bus_id_fifo
// Synchronous FIFO of master IDs for reads that were accepted by the slave
// but not yet answered. The head is visible combinationally so a response can
// be routed in the same cycle it arrives.
//   clk_i, arst_i  : clock, asynchronous active-low reset (FIFO emptied)
//   push_i/push_id_i : enqueue an ID (honoured when not full or popping)
//   pop_i          : dequeue the head (ignored when empty)
//   head_id_o      : ID at the head
//   full_o/empty_o : occupancy flags
//   count_o        : number of stored IDs
// ---------------------------------------------------------------------------
module bus_id_fifo
    import bus_arb_pkg::*;
#(
    parameter int ID_W  = 1,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             push_i,
    input  logic [ID_W-1:0]  push_id_i,
    input  logic             pop_i,
    output logic [ID_W-1:0]  head_id_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int              PTR_W    = idx_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [ID_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    // A push into a full FIFO is legal when the head leaves in the same cycle;
    // the write lands in the slot being vacated.
    always_comb begin
        doPop   = pop_i && (count_q != '0);
        doPush  = push_i && ((count_q != CNT_W'(DEPTH)) || doPop);
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + 1'b1;
        end
        if (doPush && !doPop) begin
            count_d = count_q + 1'b1;
        end else if (doPop && !doPush) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= push_id_i;
        end
    end

    assign head_id_o = mem_q[rdPtr_q];
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr
// N-master to 1-slave bus arbiter with fixed-priority (ARB_MODE=0) or
// round-robin (ARB_MODE=1) selection, up to MAX_OUTSTANDING pipelined reads,
// and in-order routing of read responses back to the issuing master.
//   clk_i, arst_i  : clock, asynchronous active-low reset
//   m_bus_if       : NUM_MASTERS packed master buses (arbiter is their slave)
//   s_bus_if       : single slave bus (arbiter is its master)
//   rd_pending_bo  : reads accepted by the slave and not yet answered
//   err_o          : sticky, set by a slave response with no pending read
// Request/ack and response routing are both zero-cycle pass-through.
// ---------------------------------------------------------------------------
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ARB_MODE        = ARB_FIXED
) (
    input  logic                              clk_i,
    input  logic                              arst_i,
    bus_arbiter_rr_if.slave                   m_bus_if,
    bus_arbiter_rr_if.master                  s_bus_if,
    output logic [$clog2(MAX_OUTSTANDING):0]  rd_pending_bo,
    output logic                              err_o
);

    localparam int ID_W  = idx_width(NUM_MASTERS);
    localparam int CNT_W = cnt_width(MAX_OUTSTANDING);
    localparam int BE_W  = DATA_W / 8;

    logic [NUM_MASTERS-1:0] eligible;
    logic                   readOk;
    logic                   grantValid;
    logic [ID_W-1:0]        grantIdx;
    logic                   handshake;
    logic                   readPush;
    logic                   fifoPop;
    logic [ID_W-1:0]        fifoHead;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic [CNT_W-1:0]       fifoCount;
    logic [ID_W-1:0]        rrPtr_q, rrPtr_d;
    logic                   err_q, err_d;
    int                     cand;

    // A read may be granted when the ID FIFO has room, including the room
    // freed by a response popping the head in this same cycle.
    assign fifoPop = s_bus_if.resp[0] & ~fifoEmpty;
    assign readOk  = ~fifoFull | fifoPop;

    // Grant selection. Round-robin scans downward from the farthest offset so
    // the last match written is the one closest to the pointer.
    always_comb begin
        eligible   = '0;
        grantValid = 1'b0;
        grantIdx   = '0;
        cand       = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            eligible[k] = m_bus_if.req[k] & (m_bus_if.we[k] | readOk);
        end
        if (ARB_MODE == ARB_RR) begin
            for (int off = NUM_MASTERS - 1; off >= 0; off--) begin
                cand = wrap_idx(int'(rrPtr_q) + off, NUM_MASTERS);
                if (eligible[ID_W'(cand)]) begin
                    grantValid = 1'b1;
                    grantIdx   = ID_W'(cand);
                end
            end
        end else begin
            for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
                if (eligible[k]) begin
                    grantValid = 1'b1;
                    grantIdx   = ID_W'(k);
                end
            end
        end
    end

    // Forward the granted master to the slave; everything is zero when idle.
    always_comb begin
        s_bus_if.req   = grantValid;
        s_bus_if.we    = '0;
        s_bus_if.addr  = '0;
        s_bus_if.be    = '0;
        s_bus_if.wdata = '0;
        m_bus_if.ack   = '0;
        if (grantValid) begin
            s_bus_if.we[0]         = m_bus_if.we[grantIdx];
            s_bus_if.addr          = m_bus_if.addr[int'(grantIdx)*ADDR_W +: ADDR_W];
            s_bus_if.be            = m_bus_if.be[int'(grantIdx)*BE_W +: BE_W];
            s_bus_if.wdata         = m_bus_if.wdata[int'(grantIdx)*DATA_W +: DATA_W];
            m_bus_if.ack[grantIdx] = s_bus_if.ack[0];
        end
    end

    assign handshake = grantValid & s_bus_if.ack[0];
    assign readPush  = handshake & ~m_bus_if.we[grantIdx];

    // Route a slave response to the master at the head of the ID FIFO.
    always_comb begin
        m_bus_if.resp  = '0;
        m_bus_if.rdata = '0;
        if (fifoPop) begin
            m_bus_if.resp[fifoHead]                          = 1'b1;
            m_bus_if.rdata[int'(fifoHead)*DATA_W +: DATA_W] = s_bus_if.rdata;
        end
    end

    always_comb begin
        rrPtr_d = rrPtr_q;
        if ((ARB_MODE == ARB_RR) && handshake) begin
            rrPtr_d = ID_W'(wrap_idx(int'(grantIdx) + 1, NUM_MASTERS));
        end
        err_d = err_q | (s_bus_if.resp[0] & fifoEmpty);
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            rrPtr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rrPtr_q <= rrPtr_d;
            err_q   <= err_d;
        end
    end

    bus_id_fifo #(
        .ID_W  (ID_W),
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .arst_i    (arst_i),
        .push_i    (readPush),
        .push_id_i (grantIdx),
        .pop_i     (fifoPop),
        .head_id_o (fifoHead),
        .full_o    (fifoFull),
        .empty_o   (fifoEmpty),
        .count_o   (fifoCount)
    );

    assign rd_pending_bo = fifoCount;
    assign err_o         = err_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_rr
// Two arbiter instances: dutFix (2 masters, fixed priority) and dutRr
// (3 masters, round-robin), both with 4 outstanding reads. Directed vectors
// push expected acks and responses into queues; negedge monitors pop and
// compare whenever a DUT raises an ack or response.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_rr;
    import bus_arb_pkg::*;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } respExp_t;

    logic clk   = 1'b0;
    logic arstN = 1'b0;

    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;

    int       fixAckQ[$];
    int       rrAckQ[$];
    respExp_t fixRespQ[$];
    respExp_t rrRespQ[$];

    int          t4Order [4] = '{0, 1, 1, 0};
    logic [31:0] t4Data  [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    bus_arbiter_rr_if #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32)) fixM ();
    bus_arbiter_rr_if #(.NUM_PORTS(1), .ADDR_W(32), .DATA_W(32)) fixS ();
    bus_arbiter_rr_if #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32)) rrM ();
    bus_arbiter_rr_if #(.NUM_PORTS(1), .ADDR_W(32), .DATA_W(32)) rrS ();

    logic [2:0] fixPending;
    logic       fixErr;
    logic [2:0] rrPending;
    logic       rrErr;

    bus_arbiter_rr #(
        .NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32),
        .MAX_OUTSTANDING(4), .ARB_MODE(ARB_FIXED)
    ) dutFix (
        .clk_i(clk), .arst_i(arstN), .m_bus_if(fixM), .s_bus_if(fixS),
        .rd_pending_bo(fixPending), .err_o(fixErr)
    );

    bus_arbiter_rr #(
        .NUM_MASTERS(3), .ADDR_W(32), .DATA_W(32),
        .MAX_OUTSTANDING(4), .ARB_MODE(ARB_RR)
    ) dutRr (
        .clk_i(clk), .arst_i(arstN), .m_bus_if(rrM), .s_bus_if(rrS),
        .rd_pending_bo(rrPending), .err_o(rrErr)
    );

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic expectAck(input bit onRr, input int idx);
        if (onRr) rrAckQ.push_back(idx);
        else      fixAckQ.push_back(idx);
    endtask

    task automatic expectResp(input bit onRr, input int idx, input logic [31:0] data);
        respExp_t r;
        r.idx  = idx;
        r.data = data;
        if (onRr) rrRespQ.push_back(r);
        else      fixRespQ.push_back(r);
    endtask

    // One cycle of stimulus on the round-robin instance; returns 3 time units
    // after the edge so callers can check the settled combinational outputs.
    task automatic applyStimulus(input logic [2:0] req, input logic [2:0] we,
                                 input logic ack, input logic resp,
                                 input logic [31:0] rdata);
        @(posedge clk);
        #1;
        rrM.req   = req;
        rrM.we    = we;
        rrS.ack   = ack;
        rrS.resp  = resp;
        rrS.rdata = rdata;
        #2;
    endtask

    // Scoreboard monitor for the fixed-priority instance.
    always @(negedge clk) begin
        respExp_t    r;
        int          e;
        logic [63:0] expVec;
        if (fixM.ack != '0) begin
            if (fixAckQ.size() == 0) begin
                checkOutput("fix unexpected ack", 128'(fixM.ack), 128'(0));
            end else begin
                e = fixAckQ.pop_front();
                checkOutput("fix ack", 128'(fixM.ack), 128'(1) << e);
            end
        end
        if (fixM.resp != '0) begin
            if (fixRespQ.size() == 0) begin
                checkOutput("fix unexpected resp", 128'(fixM.resp), 128'(0));
            end else begin
                r      = fixRespQ.pop_front();
                expVec = '0;
                expVec[r.idx*32 +: 32] = r.data;
                checkOutput("fix resp", 128'(fixM.resp), 128'(1) << r.idx);
                checkOutput("fix rdata", 128'(fixM.rdata), 128'(expVec));
            end
        end
    end

    // Scoreboard monitor for the round-robin instance.
    always @(negedge clk) begin
        respExp_t    r;
        int          e;
        logic [95:0] expVec;
        if (rrM.ack != '0) begin
            if (rrAckQ.size() == 0) begin
                checkOutput("rr unexpected ack", 128'(rrM.ack), 128'(0));
            end else begin
                e = rrAckQ.pop_front();
                checkOutput("rr ack", 128'(rrM.ack), 128'(1) << e);
            end
        end
        if (rrM.resp != '0) begin
            if (rrRespQ.size() == 0) begin
                checkOutput("rr unexpected resp", 128'(rrM.resp), 128'(0));
            end else begin
                r      = rrRespQ.pop_front();
                expVec = '0;
                expVec[r.idx*32 +: 32] = r.data;
                checkOutput("rr resp", 128'(rrM.resp), 128'(1) << r.idx);
                checkOutput("rr rdata", 128'(rrM.rdata), 128'(expVec));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        fixM.req   = '0;
        fixM.we    = '0;
        fixM.addr  = {32'h0000_0200, 32'h0000_0100};
        fixM.be    = '1;
        fixM.wdata = {32'h0000_00B1, 32'h0000_00A0};
        fixS.ack   = '0;
        fixS.resp  = '0;
        fixS.rdata = '0;
        rrM.req    = '0;
        rrM.we     = '0;
        rrM.addr   = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        rrM.be     = '1;
        rrM.wdata  = {32'h0000_00C2, 32'h0000_00B1, 32'h0000_00A0};
        rrS.ack    = '0;
        rrS.resp   = '0;
        rrS.rdata  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        checkOutput("reset fix pending", 128'(fixPending), 128'(0));
        checkOutput("reset fix err", 128'(fixErr), 128'(0));
        checkOutput("reset fix s_req", 128'(fixS.req), 128'(0));
        checkOutput("reset rr pending", 128'(rrPending), 128'(0));
        checkOutput("reset rr err", 128'(rrErr), 128'(0));
        checkOutput("reset rr s_req", 128'(rrS.req), 128'(0));
        @(posedge clk);
        #1;
        arstN = 1'b1;

        // Fixed priority: both masters read, master 0 wins every cycle
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            #1;
            fixM.req   = (c < 6) ? 2'b11 : 2'b00;
            fixS.ack   = (c < 6) ? 1'b1 : 1'b0;
            fixS.resp  = (c > 0) ? 1'b1 : 1'b0;
            fixS.rdata = 32'hDEAD_BEEF;
            #2;
            if (c < 6) begin
                expectAck(1'b0, 0);
                checkOutput("fix grant addr", 128'(fixS.addr), 128'(32'h100));
                checkOutput("fix m1 starved", 128'(fixM.ack[1]), 128'(0));
            end
            if (c > 0) expectResp(1'b0, 0, 32'hDEAD_BEEF);
        end
        @(posedge clk);
        #1;
        fixS.resp = '0;
        fixS.ack  = '0;
        #2;
        checkOutput("fix pending drained", 128'(fixPending), 128'(0));

        // Round-robin writes: 0,1,2,0,1,2
        for (int c = 0; c < 6; c++) begin
            applyStimulus(3'b111, 3'b111, 1'b1, 1'b0, 32'h0);
            expectAck(1'b1, c % 3);
            checkOutput("rr write addr", 128'(rrS.addr), 128'(32'h1000 * (c % 3 + 1)));
        end
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        checkOutput("rr writes no pending", 128'(rrPending), 128'(0));

        // Outstanding limit
        for (int c = 0; c < 4; c++) begin
            applyStimulus(3'b010, 3'b000, 1'b1, 1'b0, 32'h0);
            expectAck(1'b1, 1);
        end
        applyStimulus(3'b010, 3'b000, 1'b1, 1'b0, 32'h0);
        checkOutput("rr pending full", 128'(rrPending), 128'(4));
        checkOutput("rr 5th read ack", 128'(rrM.ack), 128'(0));
        checkOutput("rr 5th read s_req", 128'(rrS.req), 128'(0));
        applyStimulus(3'b011, 3'b001, 1'b1, 1'b0, 32'h0);
        expectAck(1'b1, 0);
        checkOutput("rr write while full we", 128'(rrS.we), 128'(1));
        checkOutput("rr write while full addr", 128'(rrS.addr), 128'(32'h1000));
        applyStimulus(3'b010, 3'b000, 1'b1, 1'b1, 32'hAAAA_0001);
        expectAck(1'b1, 1);
        expectResp(1'b1, 1, 32'hAAAA_0001);
        for (int k = 2; k <= 5; k++) begin
            applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'hAAAA_0000 + 32'(k));
            expectResp(1'b1, 1, 32'hAAAA_0000 + 32'(k));
            if (k == 2) checkOutput("rr pending after pop+push", 128'(rrPending), 128'(4));
        end
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        checkOutput("rr pending drained 1", 128'(rrPending), 128'(0));

        // Interleaved reads 0,1,1,0 and in-order responses
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'(1 << t4Order[i]), 3'b000, 1'b1, 1'b0, 32'h0);
            expectAck(1'b1, t4Order[i]);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, t4Data[i]);
            expectResp(1'b1, t4Order[i], t4Data[i]);
        end
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        checkOutput("rr pending drained 2", 128'(rrPending), 128'(0));

        // Push and pop in one cycle with two pending
        applyStimulus(3'b100, 3'b000, 1'b1, 1'b0, 32'h0);
        expectAck(1'b1, 2);
        applyStimulus(3'b001, 3'b000, 1'b1, 1'b0, 32'h0);
        expectAck(1'b1, 0);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        checkOutput("rr pending two", 128'(rrPending), 128'(2));
        applyStimulus(3'b010, 3'b000, 1'b1, 1'b1, 32'h55);
        expectAck(1'b1, 1);
        expectResp(1'b1, 2, 32'h55);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        checkOutput("rr pending same push+pop", 128'(rrPending), 128'(2));
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'h66);
        expectResp(1'b1, 0, 32'h66);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'h77);
        expectResp(1'b1, 1, 32'h77);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        checkOutput("rr pending drained 3", 128'(rrPending), 128'(0));

        // Stray response sets sticky err
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'h99);
        checkOutput("rr stray no m_resp", 128'(rrM.resp), 128'(0));
        checkOutput("rr err before edge", 128'(rrErr), 128'(0));
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        checkOutput("rr err set", 128'(rrErr), 128'(1));
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        checkOutput("rr err sticky", 128'(rrErr), 128'(1));

        // Reset with three reads in flight; pointer left at 2 beforehand
        applyStimulus(3'b100, 3'b000, 1'b1, 1'b0, 32'h0);
        expectAck(1'b1, 2);
        applyStimulus(3'b001, 3'b000, 1'b1, 1'b0, 32'h0);
        expectAck(1'b1, 0);
        applyStimulus(3'b010, 3'b000, 1'b1, 1'b0, 32'h0);
        expectAck(1'b1, 1);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        checkOutput("rr pending three", 128'(rrPending), 128'(3));
        #1;
        arstN = 1'b0;
        #1;
        checkOutput("rr async reset pending", 128'(rrPending), 128'(0));
        checkOutput("rr async reset err", 128'(rrErr), 128'(0));
        @(posedge clk);
        #1;
        arstN = 1'b1;
        applyStimulus(3'b111, 3'b111, 1'b1, 1'b0, 32'h0);
        expectAck(1'b1, 0);
        checkOutput("rr pointer reset addr", 128'(rrS.addr), 128'(32'h1000));
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'h123);
        checkOutput("rr late resp dropped", 128'(rrM.resp), 128'(0));
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        checkOutput("rr late resp err", 128'(rrErr), 128'(1));

        @(posedge clk);
        #3;
        checkOutput("fix err clear", 128'(fixErr), 128'(0));
        checkOutput("fix ack queue empty", 128'(fixAckQ.size()), 128'(0));
        checkOutput("fix resp queue empty", 128'(fixRespQ.size()), 128'(0));
        checkOutput("rr ack queue empty", 128'(rrAckQ.size()), 128'(0));
        checkOutput("rr resp queue empty", 128'(rrRespQ.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
